// File: rtl/fifo_rd_unpacker.sv
// fifo_rd_unpacker
// Reads one DIN_W-bit word at a time from an upstream FIFO, then sends it
// downstream as RATIO = DIN_W/DOUT_W narrow beats with valid/ready
// handshaking. The least significant beat goes first.
//
// Ports
//   clk         single clock; all logic is on its rising edge
//   rst         synchronous active-high reset
//   fifo_empty  upstream FIFO empty flag
//   fifo_rd_en  read strobe to the upstream FIFO (combinational in IDLE)
//   fifo_dout   FIFO read data; valid the cycle after fifo_rd_en
//   out_valid   output beat valid
//   out_ready   downstream accept
//   out_data    output beat (DOUT_W bits)
//   out_last    marks the final beat of a word
//   busy        high whenever the FSM is not in IDLE
//   word_cnt    count of fully transferred words; wraps at 16 bits
//
// DIN_W must be an integer multiple of DOUT_W.
module fifo_rd_unpacker #(
    parameter int DIN_W  = 32,
    parameter int DOUT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DIN_W-1:0]  fifo_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [15:0]       word_cnt
);

    localparam int RATIO = DIN_W / DOUT_W;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [DIN_W-1:0]   shift_r;
    logic [IDX_W-1:0]   beat_idx_r;
    logic [15:0]        word_cnt_r;
    logic               xfer_s;
    logic               last_s;

    // Outputs decoded straight from registered state. The shift register has
    // been emptied by the time the FSM is back in IDLE, so out_data is zero there.
    assign out_valid = (state_r == ST_SEND);
    assign last_s    = (state_r == ST_SEND) && (beat_idx_r == LAST_IDX);
    assign out_last  = last_s;
    assign out_data  = shift_r[DOUT_W-1:0];
    assign busy      = (state_r != ST_IDLE);
    assign word_cnt  = word_cnt_r;

    // Next-state logic, FIFO read strobe and beat transfer qualifier.
    always_comb begin
        state_s    = state_r;
        fifo_rd_en = 1'b0;
        xfer_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A read is issued only from IDLE, so at most one read is outstanding.
                fifo_rd_en = !fifo_empty && !rst;
                if (!fifo_empty) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_s = ST_SEND;
            end
            ST_SEND: begin
                xfer_s = out_ready;
                if (out_ready && last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, word capture/shift, beat index and word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            beat_idx_r <= '0;
            word_cnt_r <= 16'd0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_LOAD: begin
                    shift_r    <= fifo_dout;
                    beat_idx_r <= '0;
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        shift_r    <= shift_r >> DOUT_W;
                        beat_idx_r <= beat_idx_r + IDX_W'(1);
                        if (last_s) begin
                            word_cnt_r <= word_cnt_r + 16'd1;
                        end
                    end
                end
                default: begin
                    shift_r    <= shift_r;
                    beat_idx_r <= beat_idx_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Self-checking bench for fifo_rd_unpacker (DIN_W=32, DOUT_W=8).
// A small FIFO model feeds the DUT; each word pushed also pushes its four
// expected beats into a scoreboard that the output monitor pops and checks.
module tb_fifo_rd_unpacker;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] fifo_dout  = 32'd0;
    logic        out_valid;
    logic        out_ready  = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic [15:0] word_cnt;

    int total = 0;
    int bad   = 0;
    int beats = 0;
    int cyc   = 0;

    logic [31:0] fifo_q[$];
    logic [8:0]  sb_q[$];
    int          rd_cyc_q[$];

    fifo_rd_unpacker #(.DIN_W(32), .DOUT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back({(i == 3) ? 1'b1 : 1'b0, w[8*i +: 8]});
        end
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
            if (sb_q.size() == 0 && fifo_q.size() == 0 && !busy && !fifo_rd_en) done = 1'b1;
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        if (rnd) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        fifo_q.delete();
    endtask

    // FIFO model: pop on a read strobe, present data the following cycle.
    initial begin
        logic rd;
        forever begin
            @(negedge clk);
            rd = fifo_rd_en && !rst;
            @(posedge clk);
            #1;
            if (rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Output monitor: protocol checks plus scoreboard comparison of beats.
    initial begin
        logic       prev_valid;
        logic       prev_xfer;
        logic       prev_rst;
        logic       xfer;
        logic [8:0] exp;
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
        prev_rst   = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (fifo_rd_en && fifo_empty) check("rd_while_empty", 32'd1, 32'd0);
            if (!rst && fifo_rd_en) rd_cyc_q.push_back(cyc);
            if (!rst && !prev_rst && prev_valid && !prev_xfer) check("valid_held", 32'(out_valid), 32'd1);
            if (!rst && out_valid && !prev_valid && rd_cyc_q.size() > 0)
                check("latency", 32'(cyc - rd_cyc_q[$]), 32'd2);
            xfer = !rst && out_valid && out_ready;
            if (xfer) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    check("beat", 32'({out_last, out_data}), 32'(exp));
                end
                beats++;
            end
            prev_valid = out_valid;
            prev_xfer  = xfer;
            prev_rst   = rst;
        end
    end

    // Directed and random stimulus.
    initial begin
        int n;
        bit found;

        // Reset state, with data waiting in the FIFO to prove no read in reset.
        fifo_q.push_back(32'h11111111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_wcnt", 32'(word_cnt), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        fifo_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Empty FIFO for 20 cycles.
        repeat (20) begin
            @(negedge clk);
            check("empty_rd_en", 32'(fifo_rd_en), 32'd0);
            check("empty_valid", 32'(out_valid), 32'd0);
            check("empty_busy", 32'(busy), 32'd0);
        end

        // Single word, ready held high.
        beats = 0;
        push_word(32'hDDCCBBAA);
        wait_idle(50, 1'b0);
        check("single_beats", 32'(beats), 32'd4);
        check("single_wcnt", 32'(word_cnt), 32'd1);

        // Backpressure on beat 1.
        push_word(32'h44332211);
        n = 0;
        found = 1'b0;
        while (!found && n < 50) begin
            @(negedge clk);
            n++;
            if (out_valid && out_data == 8'h11) found = 1'b1;
        end
        if (!found) check("bp_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'h22);
            check("bp_last", 32'(out_last), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle(50, 1'b0);
        check("bp_wcnt", 32'(word_cnt), 32'd2);

        // Back-to-back words from a fresh reset.
        do_reset();
        beats = 0;
        rd_cyc_q.delete();
        push_word(32'h87654321);
        push_word(32'h0FEDCBA9);
        wait_idle(80, 1'b0);
        check("b2b_rd_cnt", 32'(rd_cyc_q.size()), 32'd2);
        if (rd_cyc_q.size() == 2) check("b2b_rd_gap", 32'(rd_cyc_q[1] - rd_cyc_q[0]), 32'd6);
        check("b2b_beats", 32'(beats), 32'd8);
        check("b2b_wcnt", 32'(word_cnt), 32'd2);

        // Reset mid-word: asserted while beat 2 (0xCC) is presented.
        push_word(32'hDDCCBBAA);
        n = 0;
        found = 1'b0;
        while (!found && n < 50) begin
            @(negedge clk);
            n++;
            if (out_valid && out_data == 8'hBB) found = 1'b1;
        end
        if (!found) check("mid_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_wcnt", 32'(word_cnt), 32'd0);
        sb_q.delete();
        fifo_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_word(32'h0D0C0B0A);
        wait_idle(50, 1'b0);
        check("mid_next_wcnt", 32'(word_cnt), 32'd1);

        // Random words under random backpressure.
        for (int i = 0; i < 6; i++) push_word($urandom);
        wait_idle(600, 1'b1);
        check("rand_wcnt", 32'(word_cnt), 32'd7);

        // Counter wrap: preload to 0xFFFF, then one more word.
        @(negedge clk);
        force dut.word_cnt_r = 16'hFFFF;
        #1;
        release dut.word_cnt_r;
        push_word(32'hCAFEF00D);
        wait_idle(50, 1'b0);
        check("wrap_wcnt", 32'(word_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
